// File: rtl/systolic_pkg.sv
// Shared constants and FSM state type for the 16x16 systolic convolution engine.
// The derived sizes here assume the default engine geometry.
package systolic_pkg;

    localparam int DEF_SYSTOLIC_SIZE = 16;
    localparam int DEF_IFM_SIZE      = 34;
    localparam int DEF_IFM_CHANNEL   = 32;
    localparam int DEF_KERNEL_SIZE   = 3;
    localparam int DEF_NO_FILTER     = 64;

    localparam int OFM_SIZE       = DEF_IFM_SIZE - DEF_KERNEL_SIZE + 1;
    localparam int TILES_PER_LINE = OFM_SIZE / DEF_SYSTOLIC_SIZE;
    localparam int NO_TILING      = TILES_PER_LINE * OFM_SIZE;
    localparam int NO_FGRP        = DEF_NO_FILTER / DEF_SYSTOLIC_SIZE;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_WGT,
        LOAD_IFM,
        COMPUTE,
        STORE_OFM,
        NEXT,
        DONE
    } sched_state_t;

    // A counter for n values needs at least one bit even when n is 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// Filter-group / tile / row / col counters and the three registered RAM base addresses.
// Addresses are computed from the next counter values so they change together with the counters.
module tile_addr_gen
    import systolic_pkg::*;
#(
    parameter int SYSTOLIC_SIZE = DEF_SYSTOLIC_SIZE,
    parameter int IFM_SIZE      = DEF_IFM_SIZE,
    parameter int IFM_CHANNEL   = DEF_IFM_CHANNEL,
    parameter int KERNEL_SIZE   = DEF_KERNEL_SIZE,
    parameter int NO_FILTER     = DEF_NO_FILTER,
    parameter int ADDR_WIDTH    = 20,
    localparam int OFM_DIM = IFM_SIZE - KERNEL_SIZE + 1,
    localparam int TPL     = OFM_DIM / SYSTOLIC_SIZE,
    localparam int N_TILES = TPL * OFM_DIM,
    localparam int N_GRP   = NO_FILTER / SYSTOLIC_SIZE,
    localparam int FILT_W  = cnt_width(N_GRP),
    localparam int TILE_W  = cnt_width(N_TILES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_tile_i,
    input  logic                  inc_tile_i,
    input  logic                  inc_filter_i,
    output logic [FILT_W-1:0]     count_filter_o,
    output logic [TILE_W-1:0]     count_tiling_o,
    output logic [ADDR_WIDTH-1:0] wgt_base_addr_o,
    output logic [ADDR_WIDTH-1:0] ifm_base_addr_o,
    output logic [ADDR_WIDTH-1:0] ofm_base_addr_o
);

    localparam int ROW_W = cnt_width(OFM_DIM);
    localparam int COL_W = cnt_width(TPL);

    localparam logic [ROW_W-1:0]  ROW_MAX  = ROW_W'(OFM_DIM - 1);
    localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(TPL - 1);
    localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(N_GRP - 1);

    localparam logic [ADDR_WIDTH-1:0] WGT_STRIDE =
        ADDR_WIDTH'(SYSTOLIC_SIZE * IFM_CHANNEL * KERNEL_SIZE * KERNEL_SIZE);
    localparam logic [ADDR_WIDTH-1:0] OFM_GRP_STRIDE = ADDR_WIDTH'(SYSTOLIC_SIZE * OFM_DIM * OFM_DIM);
    localparam logic [ADDR_WIDTH-1:0] IFM_ROW_STRIDE = ADDR_WIDTH'(IFM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] OFM_ROW_STRIDE = ADDR_WIDTH'(OFM_DIM);
    localparam logic [ADDR_WIDTH-1:0] COL_STRIDE     = ADDR_WIDTH'(SYSTOLIC_SIZE);

    logic [FILT_W-1:0] filt_q, filt_d;
    logic [TILE_W-1:0] tile_q, tile_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ADDR_WIDTH-1:0] wgt_addr_q, ifm_addr_q, ofm_addr_q;

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        filt_d = filt_q;
        tile_d = tile_q;
        row_d  = row_q;
        col_d  = col_q;
        if (clr_tile_i) begin
            tile_d = '0;
            row_d  = '0;
            col_d  = '0;
        end else if (inc_tile_i) begin
            tile_d = tile_q + 1'b1;
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        // Group counter wraps so a finished run leaves every counter back at zero.
        if (inc_filter_i) begin
            filt_d = (filt_q == FILT_MAX) ? '0 : filt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q     <= '0;
            tile_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            wgt_addr_q <= '0;
            ifm_addr_q <= '0;
            ofm_addr_q <= '0;
        end else begin
            filt_q     <= filt_d;
            tile_q     <= tile_d;
            row_q      <= row_d;
            col_q      <= col_d;
            wgt_addr_q <= ADDR_WIDTH'(filt_d) * WGT_STRIDE;
            ifm_addr_q <= ADDR_WIDTH'(row_d) * IFM_ROW_STRIDE + ADDR_WIDTH'(col_d) * COL_STRIDE;
            ofm_addr_q <= ADDR_WIDTH'(filt_d) * OFM_GRP_STRIDE
                        + ADDR_WIDTH'(row_d) * OFM_ROW_STRIDE + ADDR_WIDTH'(col_d) * COL_STRIDE;
        end
    end

    assign count_filter_o  = filt_q;
    assign count_tiling_o  = tile_q;
    assign wgt_base_addr_o = wgt_addr_q;
    assign ifm_base_addr_o = ifm_addr_q;
    assign ofm_base_addr_o = ofm_addr_q;

endmodule

// File: rtl/conv_tile_scheduler.sv
// Loop sequencer: filter groups outer, output tiles inner, one req/ack handshake per phase.
// Optional SCHED_PERF_CNT_EN adds cycle_count / stall_count monitoring outputs.
module conv_tile_scheduler
    import systolic_pkg::*;
#(
    parameter int SYSTOLIC_SIZE = DEF_SYSTOLIC_SIZE,
    parameter int IFM_SIZE      = DEF_IFM_SIZE,
    parameter int IFM_CHANNEL   = DEF_IFM_CHANNEL,
    parameter int KERNEL_SIZE   = DEF_KERNEL_SIZE,
    parameter int NO_FILTER     = DEF_NO_FILTER,
    parameter int ADDR_WIDTH    = 20,
    localparam int OFM_DIM = IFM_SIZE - KERNEL_SIZE + 1,
    localparam int N_TILES = (OFM_DIM / SYSTOLIC_SIZE) * OFM_DIM,
    localparam int N_GRP   = NO_FILTER / SYSTOLIC_SIZE,
    localparam int FILT_W  = cnt_width(N_GRP),
    localparam int TILE_W  = cnt_width(N_TILES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  done,
    output logic                  busy,
    output logic                  wgt_req,
    input  logic                  wgt_ack,
    output logic [ADDR_WIDTH-1:0] wgt_base_addr,
    output logic                  ifm_req,
    input  logic                  ifm_ack,
    output logic [ADDR_WIDTH-1:0] ifm_base_addr,
    output logic                  cmp_req,
    input  logic                  cmp_ack,
    output logic                  ofm_req,
    input  logic                  ofm_ack,
    output logic [ADDR_WIDTH-1:0] ofm_base_addr,
`ifdef SCHED_PERF_CNT_EN
    output logic [31:0]           cycle_count,
    output logic [31:0]           stall_count,
`endif
    output logic [FILT_W-1:0]     count_filter,
    output logic [TILE_W-1:0]     count_tiling
);

    localparam logic [TILE_W-1:0] TILE_LAST = TILE_W'(N_TILES - 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(N_GRP - 1);

    sched_state_t state_q, state_d;
    logic clr_tile, inc_tile, inc_filter;

    always_comb begin
        state_d    = state_q;
        clr_tile   = 1'b0;
        inc_tile   = 1'b0;
        inc_filter = 1'b0;
        unique case (state_q)
            IDLE:      if (start)   state_d = LOAD_WGT;
            LOAD_WGT:  if (wgt_ack) state_d = LOAD_IFM;
            LOAD_IFM:  if (ifm_ack) state_d = COMPUTE;
            COMPUTE:   if (cmp_ack) state_d = STORE_OFM;
            STORE_OFM: if (ofm_ack) state_d = NEXT;
            NEXT: begin
                if (count_tiling != TILE_LAST) begin
                    inc_tile = 1'b1;
                    state_d  = LOAD_IFM;
                end else begin
                    clr_tile   = 1'b1;
                    inc_filter = 1'b1;
                    state_d    = (count_filter == FILT_LAST) ? DONE : LOAD_WGT;
                end
            end
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Outputs decode the registered state only, so each req spans its whole state.
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign wgt_req = (state_q == LOAD_WGT);
    assign ifm_req = (state_q == LOAD_IFM);
    assign cmp_req = (state_q == COMPUTE);
    assign ofm_req = (state_q == STORE_OFM);

    tile_addr_gen #(
        .SYSTOLIC_SIZE (SYSTOLIC_SIZE),
        .IFM_SIZE      (IFM_SIZE),
        .IFM_CHANNEL   (IFM_CHANNEL),
        .KERNEL_SIZE   (KERNEL_SIZE),
        .NO_FILTER     (NO_FILTER),
        .ADDR_WIDTH    (ADDR_WIDTH)
    ) u_addr_gen (
        .clk             (clk),
        .rst             (rst),
        .clr_tile_i      (clr_tile),
        .inc_tile_i      (inc_tile),
        .inc_filter_i    (inc_filter),
        .count_filter_o  (count_filter),
        .count_tiling_o  (count_tiling),
        .wgt_base_addr_o (wgt_base_addr),
        .ifm_base_addr_o (ifm_base_addr),
        .ofm_base_addr_o (ofm_base_addr)
    );

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] cycle_q, cycle_d, stall_q, stall_d;
    logic        any_stall;

    always_comb begin
        any_stall = (wgt_req & ~wgt_ack) | (ifm_req & ~ifm_ack)
                  | (cmp_req & ~cmp_ack) | (ofm_req & ~ofm_ack);
        cycle_d   = cycle_q;
        stall_d   = stall_q;
        if (state_q == IDLE && start) begin
            cycle_d = '0;
            stall_d = '0;
        end else begin
            if (busy)      cycle_d = cycle_q + 32'd1;
            if (any_stall) stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q <= '0;
            stall_q <= '0;
        end else begin
            cycle_q <= cycle_d;
            stall_q <= stall_d;
        end
    end

    assign cycle_count = cycle_q;
    assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Self-checking bench for conv_tile_scheduler: randomized ack latencies checked against a
// loop-nest reference model of the phase sequence and its base addresses.
module tb_conv_tile_scheduler;
    import systolic_pkg::*;

    localparam int AW = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic wgt_ack = 1'b0, ifm_ack = 1'b0, cmp_ack = 1'b0, ofm_ack = 1'b0;
    logic done, busy, wgt_req, ifm_req, cmp_req, ofm_req;
    logic [AW-1:0] wgt_base_addr, ifm_base_addr, ofm_base_addr;
    logic [1:0] count_filter;
    logic [5:0] count_tiling;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0] cycle_count, stall_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    conv_tile_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .done          (done),
        .busy          (busy),
        .wgt_req       (wgt_req),
        .wgt_ack       (wgt_ack),
        .wgt_base_addr (wgt_base_addr),
        .ifm_req       (ifm_req),
        .ifm_ack       (ifm_ack),
        .ifm_base_addr (ifm_base_addr),
        .cmp_req       (cmp_req),
        .cmp_ack       (cmp_ack),
        .ofm_req       (ofm_req),
        .ofm_ack       (ofm_ack),
        .ofm_base_addr (ofm_base_addr),
`ifdef SCHED_PERF_CNT_EN
        .cycle_count   (cycle_count),
        .stall_count   (stall_count),
`endif
        .count_filter  (count_filter),
        .count_tiling  (count_tiling)
    );

    // Reference address formulas, straight from the engine geometry.
    function automatic logic [AW-1:0] exp_wgt(input int g);
        return AW'(g * DEF_SYSTOLIC_SIZE * DEF_IFM_CHANNEL * DEF_KERNEL_SIZE * DEF_KERNEL_SIZE);
    endfunction
    function automatic logic [AW-1:0] exp_ifm(input int t);
        return AW'((t / TILES_PER_LINE) * DEF_IFM_SIZE + (t % TILES_PER_LINE) * DEF_SYSTOLIC_SIZE);
    endfunction
    function automatic logic [AW-1:0] exp_ofm(input int g, input int t);
        return AW'(g * DEF_SYSTOLIC_SIZE * OFM_SIZE * OFM_SIZE
                   + (t / TILES_PER_LINE) * OFM_SIZE + (t % TILES_PER_LINE) * DEF_SYSTOLIC_SIZE);
    endfunction

    task automatic start_pulse();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // which: 0 wgt, 1 ifm, 2 cmp, 3 ofm
    task automatic pulse_ack(input int which);
        @(negedge clk);
        wgt_ack = (which == 0); ifm_ack = (which == 1);
        cmp_ack = (which == 2); ofm_ack = (which == 3);
        @(negedge clk);
        wgt_ack = 1'b0; ifm_ack = 1'b0; cmp_ack = 1'b0; ofm_ack = 1'b0;
    endtask

    task automatic test_reset();
        #12 rst = 1'b0;
        @(negedge clk);
        total++; if ({done, busy, wgt_req, ifm_req, cmp_req, ofm_req} !== 6'b0) begin
            bad++; $display("FAIL reset_ctl got=%b want=000000", {done, busy, wgt_req, ifm_req, cmp_req, ofm_req}); end
        total++; if ({wgt_base_addr, ifm_base_addr, ofm_base_addr, count_filter, count_tiling} !== '0) begin
            bad++; $display("FAIL reset_addr wgt=%0d ifm=%0d ofm=%0d f=%0d t=%0d want all 0",
                            wgt_base_addr, ifm_base_addr, ofm_base_addr, count_filter, count_tiling); end
`ifdef SCHED_PERF_CNT_EN
        total++; if ({cycle_count, stall_count} !== 64'd0) begin
            bad++; $display("FAIL reset_perf cyc=%0d stall=%0d want 0", cycle_count, stall_count); end
`endif
    endtask

    task automatic test_spurious();
        start_pulse();
        total++; if (wgt_req !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL start_wgt_req got=%b busy=%b want 1", wgt_req, busy); end
        pulse_ack(0);
        @(negedge clk);
        cmp_ack = 1'b1; ofm_ack = 1'b1; wgt_ack = 1'b1; start = 1'b1;
        @(negedge clk);
        cmp_ack = 1'b0; ofm_ack = 1'b0; wgt_ack = 1'b0; start = 1'b0;
        total++; if ({wgt_req, ifm_req, cmp_req, ofm_req} !== 4'b0100) begin
            bad++; $display("FAIL spurious_state got=%b want=0100", {wgt_req, ifm_req, cmp_req, ofm_req}); end
        total++; if (count_tiling !== 6'd0 || count_filter !== 2'd0) begin
            bad++; $display("FAIL spurious_cnt f=%0d t=%0d want 0 0", count_filter, count_tiling); end
        pulse_ack(1);
        total++; if (cmp_req !== 1'b1) begin
            bad++; $display("FAIL ifm_to_cmp got=%b want 1", cmp_req); end
        pulse_ack(2);
        pulse_ack(3);
        for (int t = 1; t < 5; t++) begin
            pulse_ack(1); pulse_ack(2); pulse_ack(3);
        end
        @(negedge clk);
        total++; if (ifm_req !== 1'b1 || count_tiling !== 6'd5 || ifm_base_addr !== exp_ifm(5)) begin
            bad++; $display("FAIL walk_tile5 req=%b t=%0d ifm=%0d want 1 5 %0d",
                            ifm_req, count_tiling, ifm_base_addr, exp_ifm(5)); end
    endtask

    task automatic test_reset_mid();
        #2 rst = 1'b1;
        #1;
        total++; if ({done, busy, wgt_req, ifm_req, cmp_req, ofm_req} !== 6'b0) begin
            bad++; $display("FAIL midrst_ctl got=%b want=000000", {done, busy, wgt_req, ifm_req, cmp_req, ofm_req}); end
        total++; if ({wgt_base_addr, ifm_base_addr, ofm_base_addr, count_filter, count_tiling} !== '0) begin
            bad++; $display("FAIL midrst_addr ifm=%0d ofm=%0d t=%0d want 0", ifm_base_addr, ofm_base_addr, count_tiling); end
        @(negedge clk); rst = 1'b0;
        start_pulse();
        total++; if (wgt_req !== 1'b1 || wgt_base_addr !== '0 || count_filter !== 2'd0) begin
            bad++; $display("FAIL restart_wgt req=%b addr=%0d f=%0d want 1 0 0", wgt_req, wgt_base_addr, count_filter); end
        pulse_ack(0);
        total++; if (ifm_req !== 1'b1 || ifm_base_addr !== '0 || count_tiling !== 6'd0) begin
            bad++; $display("FAIL restart_ifm req=%b addr=%0d t=%0d want 1 0 0", ifm_req, ifm_base_addr, count_tiling); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    // Full job; the sub-units answer each req after a latency of 0 (zero_lat) or 0..3 random cycles.
    task automatic run_job(input bit zero_lat);
        int n_w = 0, n_i = 0, n_c = 0, n_o = 0, n_done = 0;
        int idx = 0, last_ofm_idx = -100, done_idx = -1;
        int lat = 0, wait_cnt = 0, sum_lat = 0, n_phase = 0;
        int g, t;
        bit pw = 0, pi = 0, pc = 0, po = 0, finished = 0;
        @(negedge clk); start = 1'b1;
        while (idx < 20000 && !finished) begin
            @(negedge clk);
            start = 1'b0; idx++;
            wgt_ack = 1'b0; ifm_ack = 1'b0; cmp_ack = 1'b0; ofm_ack = 1'b0;
            if (done === 1'b1) begin n_done++; done_idx = idx; end
            if (done_idx > 0 && idx == done_idx + 1) begin
                finished = 1;
                total++; if (busy !== 1'b0 || count_filter !== 2'd0 || count_tiling !== 6'd0) begin
                    bad++; $display("FAIL end_idle busy=%b f=%0d t=%0d want 0 0 0", busy, count_filter, count_tiling); end
            end
            if (wgt_req && !pw) begin
                g = n_w;
                total++; if (count_filter !== 2'(g) || count_tiling !== 6'd0 || wgt_base_addr !== exp_wgt(g)) begin
                    bad++; $display("FAIL wgt_phase g=%0d f=%0d t=%0d addr=%0d want addr %0d",
                                    g, count_filter, count_tiling, wgt_base_addr, exp_wgt(g)); end
                if (g > 0) begin
                    total++; if (idx != last_ofm_idx + 2) begin
                        bad++; $display("FAIL grp_turn g=%0d gap=%0d want 2", g, idx - last_ofm_idx); end
                end
                n_w++;
            end
            if (ifm_req && !pi) begin
                g = n_i / NO_TILING; t = n_i % NO_TILING;
                total++; if (count_filter !== 2'(g) || count_tiling !== 6'(t) || ifm_base_addr !== exp_ifm(t)) begin
                    bad++; $display("FAIL ifm_phase g=%0d t=%0d got f=%0d t=%0d addr=%0d want %0d",
                                    g, t, count_filter, count_tiling, ifm_base_addr, exp_ifm(t)); end
                n_i++;
            end
            if (cmp_req && !pc) begin
                t = n_c % NO_TILING;
                total++; if (count_tiling !== 6'(t)) begin
                    bad++; $display("FAIL cmp_phase t=%0d want %0d", count_tiling, t); end
                n_c++;
            end
            if (ofm_req && !po) begin
                g = n_o / NO_TILING; t = n_o % NO_TILING;
                total++; if (ofm_base_addr !== exp_ofm(g, t)) begin
                    bad++; $display("FAIL ofm_phase g=%0d t=%0d addr=%0d want %0d", g, t, ofm_base_addr, exp_ofm(g, t)); end
                n_o++;
            end
            if ((wgt_req && !pw) || (ifm_req && !pi) || (cmp_req && !pc) || (ofm_req && !po)) begin
                lat = zero_lat ? 0 : int'($urandom_range(3, 0));
                wait_cnt = 0; sum_lat += lat; n_phase++;
            end
            if (wgt_req || ifm_req || cmp_req || ofm_req) begin
                if (wait_cnt == lat) begin
                    wgt_ack = wgt_req; ifm_ack = ifm_req; cmp_ack = cmp_req; ofm_ack = ofm_req;
                    if (ofm_req) last_ofm_idx = idx;
                end
                wait_cnt++;
            end
            pw = wgt_req; pi = ifm_req; pc = cmp_req; po = ofm_req;
        end
        wgt_ack = 1'b0; ifm_ack = 1'b0; cmp_ack = 1'b0; ofm_ack = 1'b0;
        total++; if (!finished) begin
            bad++; $display("FAIL job_timeout cycles=%0d done_seen=%0d want completion", idx, n_done); end
        total++; if (n_w != NO_FGRP || n_i != NO_FGRP * NO_TILING || n_c != NO_FGRP * NO_TILING
                     || n_o != NO_FGRP * NO_TILING) begin
            bad++; $display("FAIL phase_counts w=%0d i=%0d c=%0d o=%0d want %0d %0d %0d %0d",
                            n_w, n_i, n_c, n_o, NO_FGRP, NO_FGRP * NO_TILING, NO_FGRP * NO_TILING, NO_FGRP * NO_TILING); end
        total++; if (n_done != 1) begin
            bad++; $display("FAIL done_pulses got=%0d want 1", n_done); end
        total++; if (done_idx != last_ofm_idx + 2) begin
            bad++; $display("FAIL done_latency gap=%0d want 2", done_idx - last_ofm_idx); end
`ifdef SCHED_PERF_CNT_EN
        total++; if (stall_count !== 32'(sum_lat)) begin
            bad++; $display("FAIL stall_count got=%0d want %0d", stall_count, sum_lat); end
        if (zero_lat) begin
            total++; if (cycle_count !== 32'(NO_FGRP * (1 + 4 * NO_TILING) + 1)) begin
                bad++; $display("FAIL cycle_closed got=%0d want %0d", cycle_count, NO_FGRP * (1 + 4 * NO_TILING) + 1); end
        end else begin
            total++; if (cycle_count !== 32'(sum_lat + n_phase + NO_FGRP * NO_TILING + 1)) begin
                bad++; $display("FAIL cycle_count got=%0d want %0d", cycle_count, sum_lat + n_phase + NO_FGRP * NO_TILING + 1); end
        end
`else
        if (n_phase != NO_FGRP * (1 + 3 * NO_TILING)) begin
            total++; bad++; $display("FAIL phase_total got=%0d want %0d", n_phase, NO_FGRP * (1 + 3 * NO_TILING));
        end
`endif
    endtask

    task automatic test_random_job();
        run_job(1'b0);
    endtask

    task automatic test_zero_latency();
        run_job(1'b1);
    endtask

    initial begin
        test_reset();
        test_spurious();
        test_reset_mid();
        test_random_job();
        test_zero_latency();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
